// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants, helpers and the unpacked-result record
// exchanged between the divide datapath and the round/pack stage.
package posit_pkg;

  localparam int POSIT_ES  = 3;
  localparam int POSIT_N   = 64;
  localparam int POSIT_SW  = 12;
  localparam int POSIT_FW  = 64;
  localparam int POSIT_MAXW = 128;

  typedef struct packed {
    logic                       sign;
    logic                       zero;
    logic                       inf;
    logic signed [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0]        sig;
    logic                       sticky;
  } posit_unpacked_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Constants are built wide and truncated by the caller to its posit width.
  function automatic logic [POSIT_MAXW-1:0] posit_nar(input int n);
    return POSIT_MAXW'(1) << (n - 1);
  endfunction

  function automatic logic [POSIT_MAXW-1:0] posit_maxpos(input int n);
    return (POSIT_MAXW'(1) << (n - 1)) - POSIT_MAXW'(1);
  endfunction

  function automatic logic [POSIT_MAXW-1:0] posit_minpos(input int n);
    return POSIT_MAXW'(n > 0);
  endfunction

endpackage

// File: rtl/posit_regime_enc.sv
// posit_regime_enc: builds the left-aligned posit body (regime|exponent|fraction)
// with guard and sticky bits, and flags scales beyond the representable range.
module posit_regime_enc
  import posit_pkg::*;
#(
  parameter int PSTWID = 64,
  parameter int es     = POSIT_ES,
  parameter int SW     = 12,
  parameter int FW     = 64
) (
  input  logic signed [SW-1:0] k,
  input  logic [es-1:0]        e,
  input  logic [FW-2:0]        frac,
  input  logic                 sticky,
  output logic [PSTWID-2:0]    body,
  output logic                 g,
  output logic                 s,
  output logic                 sat_max,
  output logic                 sat_min
);

  localparam int VW = 2 + es + FW - 1;
  localparam int WW = VW + PSTWID;
  localparam logic signed [SW-1:0] KMAX = SW'(PSTWID - 2);
  localparam logic signed [SW-1:0] KMIN = SW'(-(PSTWID - 1));

  logic signed [WW-1:0] seed;
  logic signed [WW-1:0] shifted;
  logic [SW-1:0]        amt;

  // Seed holds the shortest regime ("10" or "01"); the arithmetic shift
  // replicates its leading bit to lengthen the run to the required size.
  assign amt     = k[SW-1] ? ~k : k;
  assign seed    = {~k[SW-1], k[SW-1], e, frac, {PSTWID{1'b0}}};
  assign shifted = seed >>> amt;

  assign body    = shifted[WW-1 -: PSTWID-1];
  assign g       = shifted[WW-PSTWID];
  assign s       = (|shifted[WW-PSTWID-1:0]) | sticky;
  assign sat_max = (k >= KMAX);
  assign sat_min = (k <= KMIN);

endmodule

// File: rtl/posit_round_pack.sv
// posit_round_pack: two-stage round-to-nearest-even posit packer with valid/ready.
// Optional macro POSIT_RP_STATUS_EN adds registered o_inexact and o_sat outputs.
module posit_round_pack
  import posit_pkg::*;
#(
  parameter int PSTWID = 64,
  parameter int es     = POSIT_ES,
  parameter int SW     = 12,
  parameter int FW     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_sign,
  input  logic                 i_zero,
  input  logic                 i_inf,
  input  logic signed [SW-1:0] i_scale,
  input  logic [FW-1:0]        i_sig,
  input  logic                 i_sticky,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [PSTWID-1:0]    o,
  output logic                 o_zero,
  output logic                 o_inf
`ifdef POSIT_RP_STATUS_EN
  ,
  output logic                 o_inexact,
  output logic                 o_sat
`endif
);

  localparam logic [PSTWID-1:0] NAR    = PSTWID'(posit_nar(PSTWID));
  localparam logic [PSTWID-1:0] MAXPOS = PSTWID'(posit_maxpos(PSTWID));
  localparam logic [PSTWID-1:0] MINPOS = PSTWID'(posit_minpos(PSTWID));

  logic                 s1_adv, s2_adv;
  logic signed [SW-1:0] k;
  logic [PSTWID-2:0]    enc_body;
  logic                 enc_g, enc_s, enc_max, enc_min;

  logic                 s1_valid, s1_sign, s1_zero, s1_inf;
  logic [PSTWID-2:0]    s1_body;
  logic                 s1_g, s1_s, s1_max, s1_min;

  logic [PSTWID-1:0]    rounded, mag, packed_o;
  logic                 inc;

  assign s2_adv  = !o_valid || o_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign i_ready = s1_adv;

  assign k = i_scale >>> es;

  posit_regime_enc #(
    .PSTWID (PSTWID),
    .es     (es),
    .SW     (SW),
    .FW     (FW)
  ) u_enc (
    .k       (k),
    .e       (i_scale[es-1:0]),
    .frac    (i_sig[FW-2:0]),
    .sticky  (i_sticky),
    .body    (enc_body),
    .g       (enc_g),
    .s       (enc_s),
    .sat_max (enc_max),
    .sat_min (enc_min)
  );

  // A significand without its hidden bit has no value, so it packs as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_body  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_max   <= 1'b0;
      s1_min   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sign <= i_sign;
        s1_zero <= i_zero | (~i_inf & ~i_sig[FW-1]);
        s1_inf  <= i_inf;
        s1_body <= enc_body;
        s1_g    <= enc_g;
        s1_s    <= enc_s;
        s1_max  <= enc_max;
        s1_min  <= enc_min;
      end
    end
  end

  assign inc     = s1_g & (s1_body[0] | s1_s);
  assign rounded = {1'b0, s1_body} + {{(PSTWID-1){1'b0}}, inc};

  always_comb begin
    mag = rounded;
    if (s1_max || rounded[PSTWID-1])
      mag = MAXPOS;
    else if (s1_min || rounded == '0)
      mag = MINPOS;
    packed_o = s1_sign ? -mag : mag;
    if (s1_inf)
      packed_o = NAR;
    else if (s1_zero)
      packed_o = '0;
  end

`ifdef POSIT_RP_STATUS_EN
  logic s2_clamp, s2_special;
  assign s2_clamp   = s1_max | s1_min | rounded[PSTWID-1] | (rounded == '0);
  assign s2_special = s1_inf | s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_inexact <= 1'b0;
      o_sat     <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      o_inexact <= ~s2_special & (s1_g | s1_s | s2_clamp);
      o_sat     <= ~s2_special & s2_clamp;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o       <= '0;
      o_zero  <= 1'b0;
      o_inf   <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o      <= packed_o;
        o_zero <= s1_zero;
        o_inf  <= s1_inf;
      end
    end
  end

endmodule
